// File: rtl/piso_serializer.sv
// Parallel-in serial-out framer, MSB first, with a one-word holding buffer for gap-free frames.
// Optional even-parity bit after the LSB is compiled in by defining PISO_PARITY_EN.
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             last_bit
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] shifter;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic [CW-1:0]    bit_cnt;
`ifdef PISO_PARITY_EN
    logic             parity;
`endif

    logic             accept;
    logic             frame_end;
    logic             start;
    logic [WIDTH-1:0] start_word;

    assign in_ready = rst & ~hold_full;

    always_comb begin
        accept     = in_valid & in_ready;
        start_word = hold_full ? hold_data : in_data;
`ifdef PISO_PARITY_EN
        frame_end  = (state == PARITY);
`else
        frame_end  = (state == SHIFT) && (bit_cnt == '0);
`endif
        // A pending buffered word always wins; in_ready is low then, so no accept can collide.
        start      = ((state == IDLE) && accept) || (frame_end && (hold_full || accept));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            shifter      <= '0;
            hold_data    <= '0;
            hold_full    <= 1'b0;
            bit_cnt      <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            last_bit     <= 1'b0;
`ifdef PISO_PARITY_EN
            parity       <= 1'b0;
`endif
        end else if (start) begin
            state        <= SHIFT;
            shifter      <= {start_word[WIDTH-2:0], 1'b0};
            serial_out   <= start_word[WIDTH-1];
            serial_valid <= 1'b1;
            last_bit     <= 1'b0;
            bit_cnt      <= CW'(WIDTH - 1);
            hold_full    <= 1'b0;
`ifdef PISO_PARITY_EN
            parity       <= ^start_word;
`endif
        end else if (frame_end) begin
            state        <= IDLE;
            shifter      <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            last_bit     <= 1'b0;
        end else if (state == SHIFT) begin
            // bit_cnt holds the number of data bits still to follow the one on serial_out
            if (bit_cnt != '0) begin
                serial_out <= shifter[WIDTH-1];
                shifter    <= {shifter[WIDTH-2:0], 1'b0};
                bit_cnt    <= bit_cnt - CW'(1);
`ifndef PISO_PARITY_EN
                last_bit   <= (bit_cnt == CW'(1));
`endif
            end
`ifdef PISO_PARITY_EN
            else begin
                state      <= PARITY;
                serial_out <= parity;
                last_bit   <= 1'b1;
            end
`endif
            if (accept) begin
                hold_data <= in_data;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Randomized bench for piso_serializer (WIDTH=4) against a bit-queue reference model,
// with a 4-bit SIPO loopback on serial_out.
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         serial_out;
    logic         serial_valid;
    logic         last_bit;
    logic [W-1:0] sipo;

    int n_checks = 0;
    int n_fail   = 0;

    bit           q[$];
    bit           bufm;
    logic [W-1:0] bufw;
    logic [W-1:0] cur_word;
    bit           loop_pending;
    logic [W-1:0] loop_word;

    piso_serializer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .serial_out  (serial_out),
        .serial_valid(serial_valid),
        .last_bit    (last_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst)             sipo <= '0;
        else if (serial_valid) sipo <= {sipo[W-2:0], serial_out};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push_frame(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) q.push_back(w[i]);
`ifdef PISO_PARITY_EN
        q.push_back(^w);
`endif
        cur_word = w;
    endfunction

    task automatic check_outputs();
        chk("serial_valid", serial_valid, q.size() != 0);
        chk("serial_out", serial_out, (q.size() != 0) ? q[0] : 1'b0);
        chk("last_bit", last_bit, q.size() == 1);
    endtask

    task automatic step(input bit v, input logic [W-1:0] d);
        bit acc;
        bit was_last;
        in_valid = v;
        in_data  = d;
        #1;
        chk("in_ready", in_ready, rst && !bufm);
        acc = v && rst && !bufm;
        @(posedge clk);
        if (q.size() == 0) begin
            if (acc) push_frame(d);
        end else begin
            was_last = (q.size() == 1);
            void'(q.pop_front());
            if (was_last) begin
                if (bufm) begin
                    push_frame(bufw);
                    bufm = 1'b0;
                end else if (acc) begin
                    push_frame(d);
                end
            end else if (acc) begin
                bufm = 1'b1;
                bufw = d;
            end
        end
        #1;
        check_outputs();
`ifndef PISO_PARITY_EN
        if (loop_pending) chk("loopback", sipo, loop_word);
        loop_pending = (q.size() == 1);
        loop_word    = cur_word;
`endif
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        #1;
        q.delete();
        bufm         = 1'b0;
        loop_pending = 1'b0;
        check_outputs();
        chk("in_ready_rst", in_ready, 1'b0);
        for (int i = 0; i < cycles; i++) begin
            in_valid = 1'($urandom);
            in_data  = W'($urandom);
            @(posedge clk);
            #1;
            check_outputs();
            chk("in_ready_rst", in_ready, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("in_ready_release", in_ready, 1'b1);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, W'($urandom));
    endtask

    initial begin
        rst          = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        bufm         = 1'b0;
        bufw         = '0;
        cur_word     = '0;
        loop_pending = 1'b0;
        loop_word    = '0;
        #2;
        do_reset(2);

        // single word
        step(1'b1, 4'b1101);
        idle_steps(6);

        // back-to-back, then a third word held under backpressure
        step(1'b1, 4'b1011);
        step(1'b1, 4'b0110);
        for (int i = 0; i < 4; i++) step(1'b1, 4'b1111);
        idle_steps(12);

        // reset mid-frame with a word buffered
        step(1'b1, 4'b1001);
        step(1'b1, 4'b0101);
        step(1'b0, 4'b0000);
        do_reset(2);
        step(1'b1, 4'b0011);
        idle_steps(7);

        // loopback word
        step(1'b1, 4'b0110);
        idle_steps(7);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset($urandom_range(0, 2));
            step($urandom_range(0, 3) != 0, W'($urandom));
        end
        idle_steps(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, parallel word width (legal values 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_data  input  WIDTH  parallel word to serialize.
REQ-005 SHALL have port: in_valid  input  1  in_data is valid.
REQ-006 SHALL have port: in_ready  output  1  block can accept a word; a transfer occurs on a rising edge with in_valid and in_ready both high.
REQ-007 SHALL have port: serial_out  output  1  serial bit stream, MSB first; feeds the downstream SIPO serial_in.
REQ-008 SHALL have port: serial_valid  output  1  serial_out carries a valid bit this cycle.
REQ-009 SHALL have port: last_bit  output  1  the current serial_out bit is the final bit of the frame.

Function
REQ-010 SHALL implement the states IDLE, SHIFT and PARITY; the PARITY state is reachable only with PISO_PARITY_EN.
REQ-011 SHALL contain a WIDTH-bit shift register, a WIDTH-bit holding buffer with a full flag, and a bit counter sized for WIDTH+1.
REQ-012 SHALL drive in_ready = (rst high) AND (holding buffer empty), combinationally.
REQ-013 SHALL, when a word is accepted in IDLE, load it directly into the shifter and enter SHIFT; the buffer stays empty.
REQ-014 SHALL, when a word is accepted in SHIFT or PARITY, store it in the holding buffer and set the full flag.
REQ-015 SHALL register serial_out: its MSB appears in the cycle after the accepting edge, followed by one bit per cycle down to the LSB.
REQ-016 SHALL hold serial_valid high for exactly the bit cycles of each frame and low otherwise.
REQ-017 SHALL assert last_bit only in the final cycle of a frame: the LSB cycle, or the parity cycle when PISO_PARITY_EN is defined.
REQ-018 SHALL, on the edge ending a frame with the buffer full, move the buffer into the shifter and clear the full flag, with no idle gap (contiguous frames).
REQ-019 SHALL, on the edge ending a frame with the buffer empty and an accept occurring on that same edge, load the new word directly into the shifter with no gap.
REQ-020 SHALL, on the edge ending a frame with no word pending, return to IDLE, with serial_out=0, serial_valid=0 and last_bit=0.
REQ-021 SHALL ignore in_data whenever in_valid is low; in_data changes while in_ready is low SHALL have no effect.

Reset
REQ-022 SHALL, while rst is low, asynchronously force: state=IDLE, serial_out=0, serial_valid=0, last_bit=0, in_ready=0, buffer flag empty, counter=0, shifter=0.
REQ-023 SHALL abort any frame in progress on reset assertion and discard the buffered word; no partial frame resumes after reset.
REQ-024 SHALL raise in_ready in the same cycle rst deasserts; the first accept is possible on the first rising edge with rst high.

Configuration
REQ-025 SHALL compile an even-parity bit in when the macro PISO_PARITY_EN is defined: after the LSB, one PARITY cycle drives serial_out = XOR of the word, with serial_valid=1 and last_bit=1; frame length is WIDTH+1.
REQ-026 SHALL, without PISO_PARITY_EN, produce WIDTH-bit frames, omit the PARITY state and parity logic, and behave otherwise identically.

Verification (WIDTH=4)
REQ-027 SHALL cover single word: accept 4'b1101 at edge 0 -> serial_out 1,1,0,1 in cycles 1-4, serial_valid high cycles 1-4, last_bit only in cycle 4, IDLE in cycle 5.
REQ-028 SHALL cover back-to-back: 4'b1011 then 4'b0110 offered continuously -> 8 contiguous valid bits 1,0,1,1,0,1,1,0; in_ready low from edge 1 until edge 4, then high.
REQ-029 SHALL cover backpressure: a third word 4'b1111 held valid while the buffer is full -> not accepted until in_ready rises, then transmitted intact after the second word.
REQ-030 SHALL cover reset mid-frame: rst low after 2 bits of 4'b1001 with 4'b0101 buffered -> all outputs 0 immediately; after release, 4'b0011 serializes as 0,0,1,1 with no residue.
REQ-031 SHALL cover parity build: with PISO_PARITY_EN, 4'b1101 -> 1,1,0,1,1 (5 bits, last_bit on bit 5); 4'b1001 -> 1,0,0,1,0.
REQ-032 SHALL cover loopback: serial_out tied to the downstream 4-bit SIPO serial_in, with SIPO shifting only on serial_valid, 4'b0110 -> SIPO parallel_out equals 4'b0110 one cycle after last_bit.
